pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush squash and saturating perf counters.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              FLUSH,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              in_xfer;
  logic              out_xfer;
  logic              live;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign live     = out_valid_q | skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (FLUSH) begin
      out_valid_d  = 1'b0;
      out_data_d   = BUBBLE_VAL;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_xfer) begin
      // Output slot is free this edge: the skid entry is older than any new input.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE_VAL;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = ~out_valid_q | out_ready;
  assign live     = out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (FLUSH) begin
      out_valid_d = 1'b0;
      out_data_d  = BUBBLE_VAL;
    end else if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && !FLUSH && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (FLUSH && live && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= BUBBLE_VAL;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
